// File: rtl/uart_pkg.sv
// Shared UART definitions: default character width and buffer depth,
// the character type, and pointer/count widths derived from the depth.
package uart_pkg;

    localparam int UART_WIDTH = 8;
    localparam int UART_DEPTH = 16;

    typedef logic [UART_WIDTH-1:0] uart_char_t;

    localparam int UART_PTR_W = $clog2(UART_DEPTH);
    localparam int UART_CNT_W = UART_PTR_W + 1;

endpackage

// File: rtl/uart_edge_detect.sv
// Registered rising-edge detector. The history register resets to
// RESET_VALUE, so a level that is already high when reset releases is not
// reported as an edge when RESET_VALUE is 1.
module uart_edge_detect #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic level_i,
    output logic rise_o
);

    logic level_q;

    // Remember the previous level so a new high level can be recognised.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_q <= RESET_VALUE;
        end else begin
            level_q <= level_i;
        end
    end

    assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side character buffer. Converts the receiver's completion level
// into one push per character, stores up to DEPTH characters and offers
// them to the consumer as a show-ahead valid/ready stream, with occupancy
// and a sticky overflow flag for characters that had to be dropped.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_WIDTH,
    parameter int DEPTH = UART_DEPTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       rx_ready,
    input  logic [WIDTH-1:0]           rx_data,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       clear_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic push;
    logic pop;
    logic full;
    logic accept;
    logic drop;

    // History resets high so a level held across reset release is ignored.
    uart_edge_detect #(
        .RESET_VALUE (1'b1)
    ) u_push_detect (
        .clock   (clock),
        .reset   (reset),
        .level_i (rx_ready),
        .rise_o  (push)
    );

    assign full      = (count_q == FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    // A simultaneous pop frees a slot, so a push at full is still taken.
    assign accept    = push & (~full | pop);
    assign drop      = push & full & ~pop;

    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (accept && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!accept && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // Control state; reset discards all stored characters at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Character storage is not reset; only accepted pushes write it.
    always_ff @(posedge clock) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver in the buffered UART path. It converts the receiver's level-style `ready`/`data` completion into single-byte pushes, stores up to `DEPTH` characters, and presents them to the consumer as a valid/ready stream. It also reports occupancy and a sticky overflow flag, so that a slow consumer never silently corrupts data.

## Interface
Parameters:
- `WIDTH`, 8: character width; must match the receiver's interface `width`.
- `DEPTH`, 16: entry count; a power of two, ≥ 2.

Ports:
- `clock`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_ready`  in  1  receiver completion level. It goes high when a character is done and stays high for about two bit times.
- `rx_data`  in  `WIDTH`  receiver character; stable whenever `rx_ready`=1.
- `out_valid`  out  1  head entry available.
- `out_data`  out  `WIDTH`  head entry; meaningful only when `out_valid`=1.
- `out_ready`  in  1  consumer accepts the head this cycle.
- `count`  out  `$clog2(DEPTH)+1`  current occupancy, 0..`DEPTH`.
- `overflow`  out  1  sticky flag: at least one character was dropped.
- `clear_overflow`  in  1  synchronous clear of `overflow`.

## Operation
- **Push detect:** `rx_ready_q` is a registered copy of `rx_ready`. A push request `push` = `rx_ready & ~rx_ready_q`, so there is exactly one push per character regardless of how long `rx_ready` stays high.
- **Pop:** `pop` = `out_valid & out_ready`.
- **Storage:** a `DEPTH`-entry register array with `wr_ptr` and `rd_ptr`, each `$clog2(DEPTH)` bits. Pointers wrap naturally modulo `DEPTH`. Full/empty are derived from `count`, not from pointer equality.
- **Head presentation:** `out_data` = `mem[rd_ptr]`, read combinationally (show-ahead). `out_valid` = (`count` != 0).
- **Accept rules:**
  - Not full, push only: write `rx_data` at `wr_ptr`, `wr_ptr`+1, `count`+1.
  - Pop only: `rd_ptr`+1, `count`−1.
  - Push and pop together, not full: both happen, `count` unchanged.
  - Push and pop together while full: the pop frees the slot and the push is accepted. Both pointers advance and `count` stays at `DEPTH`.
  - Push while full with no pop: the character is dropped, `overflow` is set, and pointers and `count` are unchanged.
  - Pop while empty: impossible, because `out_valid`=0.
- **Overflow flag:** `overflow` is set by a drop and cleared by `clear_overflow`. If a drop and `clear_overflow` occur in the same cycle, set wins.
- **Data ordering:** no reordering and no bypass. An empty FIFO never forwards `rx_data` in the same cycle it is pushed.

## Timing
- **Reset values:**
  - `out_valid`=0, `count`=0, `overflow`=0, `wr_ptr`=`rd_ptr`=0.
  - `rx_ready_q`=1, so that an `rx_ready` level already high across reset release is not captured as a push.
  - Memory contents are not reset; `out_data` is don't-care while `out_valid`=0.
- **Reset mid-operation:** all stored characters are discarded immediately (asynchronous reset). No push is taken until `rx_ready` has been seen low and then high again.
- **Latency:** a rising edge of `rx_ready` sampled at edge N writes at edge N. `out_valid`=1 and `out_data`=`rx_data` are visible after edge N, so the character is at the output in the cycle following the edge at which `rx_ready` is first sampled high.
- **Pop completion:** a pop completes at the clock edge where `out_valid & out_ready`=1. The next head, or `out_valid`=0, is visible after that edge.
- **Consumer stalls:** `out_ready` may be held low indefinitely. `out_data` stays stable while `out_valid`=1 and no pop occurs.
- **Outputs:** `count` and `overflow` are registered and update at the same edge as the push/pop that changes them.

## Structure
- **Shared package `uart_pkg`:**
  - Default `WIDTH` and `DEPTH` constants.
  - `uart_char_t` typedef (`logic [WIDTH-1:0]`).
  - Count/pointer width helper constants.
- **Sub-module `uart_edge_detect`:** one natural sub-module, a registered rising-edge detector. It has a reset-value parameter, here set to 1. The rest (pointer, count and flag logic plus the memory array) stays in this module.
- **Integration:** `rx_ready`/`rx_data` connect directly to the receiver's interface `ready`/`data`.

## Test plan
- **Single character:** reset; hold `rx_ready`=1 for 40 cycles with `rx_data`=0xA5 → exactly one push, `count`=1, `out_valid`=1, `out_data`=0xA5 one cycle after the first sampled high.
- **Ordering and drain:** push 0x01, 0x02, 0x03 with `out_ready`=0, then assert `out_ready` → `out_data` is 0x01, 0x02, 0x03 on consecutive cycles, then `out_valid`=0 and `count`=0.
- **Overflow:** with `DEPTH`=16, push 17 characters 0x00..0x10 with no pops → `count`=16, `overflow`=1, and the drained data is 0x00..0x0F. Then pulse `clear_overflow` → `overflow`=0.
- **Push and pop while full:** at full, a push of 0x55 coincides with `out_ready`=1 → the head is popped, 0x55 is accepted, `count` stays 16, `overflow` stays 0, and 0x55 appears as the 16th subsequent output.
- **Set wins over clear:** a drop and `clear_overflow` in the same cycle → `overflow`=1 after the edge.
- **Reset mid-operation:** with 5 entries stored and `rx_ready` high, assert `reset` asynchronously mid-cycle → `out_valid`=0 and `count`=0 immediately. After release with `rx_ready` still high, no push occurs. A fresh low-then-high `rx_ready` with 0x3C → `count`=1, `out_data`=0x3C.
